// File: rtl/vga_stream_gen.sv
// VGA raster generator: programmable timing, latency-matched frame-buffer read,
// power-of-2 downscale, mono/RGB pixel modes and a frame-latched overlay rectangle.
module vga_stream_gen #(
  parameter int unsigned H_ACT    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACT    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned COL_W    = 4,
  parameter int unsigned PIX_W    = 12,
  parameter int unsigned SCALE_SH = 0,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned ADDR_W   = 19,
  parameter logic [3*COL_W-1:0] BOX_RGB = 12'h0F0
) (
  input  logic              clk25,
  input  logic              rst_n,
  output logic              frame_rd,
  output logic [ADDR_W-1:0] frame_addr,
  input  logic [PIX_W-1:0]  frame_pixel,
  input  logic              mono,
  input  logic              box_en,
  input  logic [11:0]       box_x0,
  input  logic [11:0]       box_x1,
  input  logic [11:0]       box_y0,
  input  logic [11:0]       box_y1,
  output logic [COL_W-1:0]  vga_red,
  output logic [COL_W-1:0]  vga_green,
  output logic [COL_W-1:0]  vga_blue,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_C = 12'(H_ACT);
  localparam logic [11:0] V_ACT_C = 12'(V_ACT);
  localparam logic [11:0] HS_BEG  = 12'(H_ACT + H_FP);
  localparam logic [11:0] HS_END  = 12'(H_ACT + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG  = 12'(V_ACT + V_FP);
  localparam logic [11:0] VS_END  = 12'(V_ACT + V_FP + V_SYNC);
  localparam logic [11:0] S_MASK  = 12'((1 << SCALE_SH) - 1);
  localparam logic [ADDR_W-1:0] SRC_W = ADDR_W'(H_ACT >> SCALE_SH);
  localparam int unsigned DLY = RD_LAT + 1;

  logic [11:0]       h, v, v_nxt;
  logic [ADDR_W-1:0] row_base;
  logic              sh_en;
  logic [11:0]       sh_x0, sh_x1, sh_y0, sh_y1;
  logic              at_origin, ben, box_ok, in_x, in_y;
  logic [11:0]       bx0, bx1, by0, by1;
  logic              act0, hs0, vs0, hit0;
  logic [4:0]        ctl_pipe [DLY];
  logic [4:0]        ctl_d;
  logic [3*COL_W-1:0] rgb_nxt;

  assign v_nxt     = v + 12'd1;
  assign at_origin = (h == '0) && (v == '0);

  // The frame's first pixel uses the live box inputs, so the whole frame
  // sees the same rectangle that gets latched into the shadow registers.
  always_comb begin
    ben    = at_origin ? box_en : sh_en;
    bx0    = at_origin ? box_x0 : sh_x0;
    bx1    = at_origin ? box_x1 : sh_x1;
    by0    = at_origin ? box_y0 : sh_y0;
    by1    = at_origin ? box_y1 : sh_y1;
    act0   = (h < H_ACT_C) && (v < V_ACT_C);
    hs0    = (h >= HS_BEG) && (h < HS_END);
    vs0    = (v >= VS_BEG) && (v < VS_END);
    box_ok = ben && (bx0 <= bx1) && (by0 <= by1);
    in_x   = (h >= bx0) && (h <= bx1);
    in_y   = (v >= by0) && (v <= by1);
    hit0   = box_ok && ((((h == bx0) || (h == bx1)) && in_y) ||
                        (((v == by0) || (v == by1)) && in_x));
  end

  // Row base tracks (v >> SCALE_SH) * (H_ACT >> SCALE_SH) one line ahead of use.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      h        <= '0;
      v        <= '0;
      row_base <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      if (v == V_LAST) begin
        v        <= '0;
        row_base <= '0;
      end else begin
        v <= v_nxt;
        if ((v_nxt & S_MASK) == '0) row_base <= row_base + SRC_W;
      end
    end else begin
      h <= h + 12'd1;
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      sh_en <= 1'b0;
      sh_x0 <= '0;
      sh_x1 <= '0;
      sh_y0 <= '0;
      sh_y1 <= '0;
    end else if (at_origin) begin
      sh_en <= box_en;
      sh_x0 <= box_x0;
      sh_x1 <= box_x1;
      sh_y0 <= box_y0;
      sh_y1 <= box_y1;
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      frame_rd   <= 1'b0;
      frame_addr <= '0;
    end else begin
      frame_rd <= act0;
      if (act0) frame_addr <= row_base + ADDR_W'(h >> SCALE_SH);
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DLY; i++) ctl_pipe[i] <= '0;
    end else begin
      ctl_pipe[0] <= {act0, hs0, vs0, hit0, at_origin};
      for (int unsigned i = 1; i < DLY; i++) ctl_pipe[i] <= ctl_pipe[i-1];
    end
  end

  assign ctl_d = ctl_pipe[DLY-1];

  always_comb begin
    rgb_nxt = '0;
    if (ctl_d[4]) begin
      if (ctl_d[1])  rgb_nxt = BOX_RGB;
      else if (mono) rgb_nxt = {3{frame_pixel[COL_W-1:0]}};
      else           rgb_nxt = frame_pixel[3*COL_W-1:0];
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      {vga_red, vga_green, vga_blue} <= '0;
      vga_hsync   <= ~HS_POL;
      vga_vsync   <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      {vga_red, vga_green, vga_blue} <= rgb_nxt;
      vga_hsync   <= ctl_d[3] ? HS_POL : ~HS_POL;
      vga_vsync   <= ctl_d[2] ? VS_POL : ~VS_POL;
      frame_start <= ctl_d[0];
    end
  end

endmodule

// File: tb/tb_vga_stream_gen.sv
// Directed bench for vga_stream_gen: default timing, a small-raster RD_LAT=3
// instance with overlay/reset stimulus, and a small-raster 2x downscale instance.
module tb_vga_stream_gen;

  typedef struct { bit en; int x0, x1, y0, y1; } box_t;
  typedef struct { int f, h, v; logic [11:0] rgb; } dir_t;

  logic clk25 = 1'b0;
  always #20 clk25 = ~clk25;
  logic rst_n;

  int checks = 0;
  int failures = 0;

  // Instance A: default timing, RD_LAT=1
  logic a_rd, a_hs, a_vs, a_fs, a_mono;
  logic [18:0] a_addr;
  logic [11:0] a_pix;
  logic [3:0]  a_r, a_g, a_b;
  // Instance B: 24x12 raster (16x8 visible), RD_LAT=3, overlay driven
  logic b_rd, b_hs, b_vs, b_fs;
  logic [18:0] b_addr;
  logic [11:0] b_pix, b_p1, b_p2;
  logic [3:0]  b_r, b_g, b_b;
  logic [11:0] b_x0, b_x1, b_y0, b_y1;
  box_t        b_box;
  box_t        hist [64];
  // Instance C: same raster as B, SCALE_SH=1, RD_LAT=1
  logic c_rd, c_hs, c_vs, c_fs;
  logic [18:0] c_addr;
  logic [11:0] c_pix;
  logic [3:0]  c_r, c_g, c_b;

  assign b_x0 = 12'(b_box.x0);
  assign b_x1 = 12'(b_box.x1);
  assign b_y0 = 12'(b_box.y0);
  assign b_y1 = 12'(b_box.y1);

  dir_t dir_b [8] = '{
    '{0, 4, 3, 12'h0F0}, '{0, 7, 2, 12'h0F0}, '{0, 7, 3, 12'h037},
    '{1, 4, 5, 12'h0F0}, '{2, 4, 5, 12'h054}, '{2, 1, 1, 12'h0F0},
    '{4, 12, 2, 12'h02C}, '{6, 4, 2, 12'h024}};

  vga_stream_gen u_a (
    .clk25(clk25), .rst_n(rst_n), .frame_rd(a_rd), .frame_addr(a_addr),
    .frame_pixel(a_pix), .mono(a_mono), .box_en(1'b0),
    .box_x0(12'd0), .box_x1(12'd0), .box_y0(12'd0), .box_y1(12'd0),
    .vga_red(a_r), .vga_green(a_g), .vga_blue(a_b),
    .vga_hsync(a_hs), .vga_vsync(a_vs), .frame_start(a_fs));

  vga_stream_gen #(.H_ACT(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACT(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LAT(3)) u_b (
    .clk25(clk25), .rst_n(rst_n), .frame_rd(b_rd), .frame_addr(b_addr),
    .frame_pixel(b_pix), .mono(1'b0), .box_en(b_box.en),
    .box_x0(b_x0), .box_x1(b_x1), .box_y0(b_y0), .box_y1(b_y1),
    .vga_red(b_r), .vga_green(b_g), .vga_blue(b_b),
    .vga_hsync(b_hs), .vga_vsync(b_vs), .frame_start(b_fs));

  vga_stream_gen #(.H_ACT(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACT(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .SCALE_SH(1), .RD_LAT(1)) u_c (
    .clk25(clk25), .rst_n(rst_n), .frame_rd(c_rd), .frame_addr(c_addr),
    .frame_pixel(c_pix), .mono(1'b0), .box_en(1'b0),
    .box_x0(12'd0), .box_x1(12'd0), .box_y0(12'd0), .box_y1(12'd0),
    .vga_red(c_r), .vga_green(c_g), .vga_blue(c_b),
    .vga_hsync(c_hs), .vga_vsync(c_vs), .frame_start(c_fs));

  // Frame-buffer models: pixel value is the low 12 address bits.
  always @(posedge clk25) begin
    a_pix <= a_addr[11:0];
    c_pix <= c_addr[11:0];
    b_p1  <= b_addr[11:0];
    b_p2  <= b_p1;
    b_pix <= b_p2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] colour(input bit act, input bit hit, input logic mono,
                                         input logic [11:0] pix);
    if (!act) return 12'h000;
    if (hit)  return 12'h0F0;
    if (mono) return {pix[3:0], pix[3:0], pix[3:0]};
    return pix;
  endfunction

  function automatic bit box_hit(input int h, input int v, input box_t b);
    if (!b.en || b.x0 > b.x1 || b.y0 > b.y1) return 1'b0;
    return ((h == b.x0 || h == b.x1) && v >= b.y0 && v <= b.y1) ||
           ((v == b.y0 || v == b.y1) && h >= b.x0 && h <= b.x1);
  endfunction

  function automatic logic mono_sched(input int p);
    int v;
    if (p < 0) return 1'b0;
    v = p / 800;
    if (v == 10) return 1'b1;
    if (v >= 5 && v <= 9) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  task automatic check_idle(input string tag, input logic [11:0] rgb, input logic hs,
                            input logic vs, input logic fs);
    check({tag, "_rgb"}, 32'(rgb), 32'h0);
    check({tag, "_hsync"}, 32'(hs), 32'h1);
    check({tag, "_vsync"}, 32'(vs), 32'h1);
    check({tag, "_fstart"}, 32'(fs), 32'h0);
  endtask

  task automatic check_rst(input string tag);
    check_idle({tag, "_A"}, {a_r, a_g, a_b}, a_hs, a_vs, a_fs);
    check({tag, "_A_rd"}, 32'(a_rd), 32'h0);
    check({tag, "_A_addr"}, 32'(a_addr), 32'h0);
    check_idle({tag, "_B"}, {b_r, b_g, b_b}, b_hs, b_vs, b_fs);
    check({tag, "_B_rd"}, 32'(b_rd), 32'h0);
    check({tag, "_B_addr"}, 32'(b_addr), 32'h0);
  endtask

  task automatic check_a(input int n);
    int p, h, v, q;
    bit act;
    if (n < 3) check_idle("A_idle", {a_r, a_g, a_b}, a_hs, a_vs, a_fs);
    else begin
      p = n - 3; h = p % 800; v = (p / 800) % 525;
      act = h < 640 && v < 480;
      check("A_rgb", 32'({a_r, a_g, a_b}), 32'(colour(act, 1'b0, a_mono, 12'(v * 640 + h))));
      check("A_hsync", 32'(a_hs), 32'(!(h >= 656 && h < 752)));
      check("A_vsync", 32'(a_vs), 32'(!(v >= 490 && v < 492)));
      check("A_fstart", 32'(a_fs), 32'(p % 420000 == 0));
      if (p == 4 * 800 + 183)  check("A_rgb_AB7", 32'({a_r, a_g, a_b}), 32'h0AB7);
      if (p == 10 * 800 + 439) check("A_mono_777", 32'({a_r, a_g, a_b}), 32'h0777);
    end
    q = n - 1; h = q % 800; v = (q / 800) % 525;
    act = h < 640 && v < 480;
    check("A_rd", 32'(a_rd), 32'(act));
    if (act) check("A_addr", 32'(a_addr), 32'(v * 640 + h));
  endtask

  task automatic check_b(input int n, input bit dir);
    int p, f, h, v, q;
    bit act;
    logic [11:0] exp_rgb;
    if (n < 5) check_idle("B_idle", {b_r, b_g, b_b}, b_hs, b_vs, b_fs);
    else begin
      p = n - 5; f = p / 288; h = p % 24; v = (p / 24) % 12;
      act = h < 16 && v < 8;
      exp_rgb = colour(act, box_hit(h, v, hist[f]), 1'b0, 12'(v * 16 + h));
      check("B_rgb", 32'({b_r, b_g, b_b}), 32'(exp_rgb));
      check("B_hsync", 32'(b_hs), 32'(!(h >= 18 && h < 21)));
      check("B_vsync", 32'(b_vs), 32'(!(v >= 9 && v < 11)));
      check("B_fstart", 32'(b_fs), 32'(p % 288 == 0));
      if (dir)
        for (int i = 0; i < 8; i++)
          if (f == dir_b[i].f && h == dir_b[i].h && v == dir_b[i].v)
            check("B_box_dir", 32'({b_r, b_g, b_b}), 32'(dir_b[i].rgb));
    end
    q = n - 1; h = q % 24; v = (q / 24) % 12;
    act = h < 16 && v < 8;
    check("B_rd", 32'(b_rd), 32'(act));
    if (act) check("B_addr", 32'(b_addr), 32'(v * 16 + h));
    if (h == 15 && v == 7) check("B_last_addr", 32'(b_addr), 32'd127);
  endtask

  task automatic check_c(input int n);
    int p, h, v, q;
    bit act;
    if (n < 3) check_idle("C_idle", {c_r, c_g, c_b}, c_hs, c_vs, c_fs);
    else begin
      p = n - 3; h = p % 24; v = (p / 24) % 12;
      act = h < 16 && v < 8;
      check("C_rgb", 32'({c_r, c_g, c_b}), 32'(colour(act, 1'b0, 1'b0, 12'((v / 2) * 8 + h / 2))));
      check("C_fstart", 32'(c_fs), 32'(p % 288 == 0));
      if ((h == 2 || h == 3) && (v == 2 || v == 3))
        check("C_block_2x2", 32'({c_r, c_g, c_b}), 32'h009);
    end
    q = n - 1; h = q % 24; v = (q / 24) % 12;
    act = h < 16 && v < 8;
    check("C_rd", 32'(c_rd), 32'(act));
    if (act) check("C_addr", 32'(c_addr), 32'((v / 2) * 8 + h / 2));
    if (h == 3 && v == 3)  check("C_addr_3_3", 32'(c_addr), 32'd9);
    if (h == 15 && v == 7) check("C_last_addr", 32'(c_addr), 32'd31);
  endtask

  // Box schedule: changes land mid-frame and must only show from the next frame.
  task automatic drive_box(input int f);
    case (f)
      1: b_box = '{1'b1, 1, 14, 1, 7};
      3: b_box = '{1'b1, 12, 3, 2, 6};
      5: b_box = '{1'b0, 4, 10, 2, 6};
      7: b_box = '{1'b1, 4, 10, 2, 6};
      default: ;
    endcase
  endtask

  localparam int N1 = 288 * 31 + 5 + 130;
  localparam int N2 = 600;

  initial begin
    rst_n  = 1'b0;
    a_mono = 1'b0;
    b_box  = '{1'b1, 4, 10, 2, 6};
    repeat (3) @(posedge clk25);
    #1 check_rst("RST_init");
    @(negedge clk25);
    rst_n   = 1'b1;
    hist[0] = b_box;
    for (int n = 1; n <= N1; n++) begin
      @(posedge clk25);
      #1;
      check_a(n);
      check_b(n, 1'b1);
      check_c(n);
      if (n % 288 == 0)   hist[n / 288] = b_box;
      if (n % 288 == 100) drive_box(n / 288);
      a_mono = mono_sched(n - 2);
    end
    // B is drawing the overlay edge at (10,5) here; reset lands mid-line.
    rst_n = 1'b0;
    #2 check_rst("RST_async");
    @(negedge clk25);
    @(negedge clk25);
    check_rst("RST_held");
    rst_n   = 1'b1;
    a_mono  = 1'b0;
    hist[0] = b_box;
    for (int n = 1; n <= N2; n++) begin
      @(posedge clk25);
      #1;
      check_a(n);
      check_b(n, 1'b0);
      check_c(n);
      if (n % 288 == 0) hist[n / 288] = b_box;
      a_mono = mono_sched(n - 2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
